// File: rtl/vga_timing_pkg.sv
// -----------------------------------------------------------------------------
// vga_timing_pkg
// Shared 640x480@60 timing constants and the vertical region encoding used by
// vga_v_fsm and vga_sync_gen.
//   - H_*/V_* default timings and derived totals
//   - 10-bit region boundaries for the horizontal decode and vertical FSM
//   - v_state_t: 2-bit vertical region state
// -----------------------------------------------------------------------------
package vga_timing_pkg;

   // Horizontal timing, in pixel clocks.
   localparam int unsigned H_VISIBLE = 640;
   localparam int unsigned H_FP      = 16;
   localparam int unsigned H_SYNC    = 96;
   localparam int unsigned H_BP      = 48;
   localparam int unsigned H_TOTAL   = H_VISIBLE + H_FP + H_SYNC + H_BP;

   // Vertical timing, in lines. The sync width carries a suffix because the
   // bare name V_SYNC is taken by the vertical state literal below.
   localparam int unsigned V_VISIBLE    = 480;
   localparam int unsigned V_FP         = 10;
   localparam int unsigned V_SYNC_LINES = 2;
   localparam int unsigned V_BP         = 33;
   localparam int unsigned V_TOTAL      = V_VISIBLE + V_FP + V_SYNC_LINES + V_BP;

   // 10-bit boundaries so every comparison against a counter is same-width.
   // Sync end bounds are exclusive.
   localparam logic [9:0] H_VIS_END     = 10'(H_VISIBLE);
   localparam logic [9:0] HS_START      = 10'(H_VISIBLE + H_FP);
   localparam logic [9:0] HS_END        = 10'(H_VISIBLE + H_FP + H_SYNC);
   localparam logic [9:0] V_FRONT_START = 10'(V_VISIBLE);
   localparam logic [9:0] V_SYNC_START  = 10'(V_VISIBLE + V_FP);
   localparam logic [9:0] V_BACK_START  = 10'(V_VISIBLE + V_FP + V_SYNC_LINES);
   localparam logic [9:0] V_LAST        = 10'(V_TOTAL - 1);

   typedef enum logic [1:0] {
      V_ACTIVE = 2'd0,
      V_FRONT  = 2'd1,
      V_SYNC   = 2'd2,
      V_BACK   = 2'd3
   } v_state_t;

   // Half-open range test [lo, hi) on unsigned 10-bit values.
   function automatic logic in_range(input logic [9:0] value,
                                     input logic [9:0] lo,
                                     input logic [9:0] hi);
      return (value >= lo) && (value < hi);
   endfunction

endpackage

// File: rtl/vga_v_fsm.sv
// -----------------------------------------------------------------------------
// vga_v_fsm
// Vertical line counter and vertical region FSM. Advances one line per trig_v
// pulse, wrapping at V_TOTAL-1, and tracks which vertical region the next line
// falls in. Region changes happen only on the boundary lines, so the FSM
// follows the counter as long as lines advance one at a time from reset.
// Ports:
//   clk, rst_n   pixel clock, synchronous active-low reset
//   trig_v       line-advance pulse (authoritative, any h position)
//   v_count      registered current line, 0..V_TOTAL-1
//   v_next       line count after this edge (combinational)
//   state_next   vertical region after this edge (combinational)
//   wrap         this edge wraps V_TOTAL-1 -> 0 (combinational)
// -----------------------------------------------------------------------------
module vga_v_fsm
   import vga_timing_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       trig_v,
   output logic [9:0] v_count,
   output logic [9:0] v_next,
   output v_state_t   state_next,
   output logic       wrap
);

   v_state_t state;

   // Line counter next value.
   always_comb begin
      wrap   = trig_v && (v_count == V_LAST);
      v_next = v_count;
      if (trig_v) begin
         v_next = wrap ? '0 : v_count + 10'd1;
      end
   end

   // Region FSM next state, keyed on the line being entered.
   always_comb begin
      // NOTE: default assignment first, so any path that matches no boundary
      // holds the state instead of inferring a latch.
      state_next = state;
      if (trig_v) begin
         if (v_next == '0) begin
            state_next = V_ACTIVE;
         end else if (v_next == V_FRONT_START) begin
            state_next = V_FRONT;
         end else if (v_next == V_SYNC_START) begin
            state_next = V_SYNC;
         end else if (v_next == V_BACK_START) begin
            state_next = V_BACK;
         end
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments, so every register here samples the
      // values that existed before this edge regardless of statement order.
      if (!rst_n) begin
         v_count <= '0;
         state   <= V_ACTIVE;
      end else begin
         v_count <= v_next;
         state   <= state_next;
      end
   end

endmodule

// File: rtl/vga_sync_gen.sv
// -----------------------------------------------------------------------------
// vga_sync_gen
// Sync/blanking generator downstream of a free-running horizontal counter.
// Owns the vertical counter (vga_v_fsm) and registers every output, so the
// sync pins and pixel coordinates are glitch-free with one cycle of latency.
// Out-of-range h_count (>= H_TOTAL) falls outside both the visible and hsync
// windows and therefore reads as blanking.
// Ports:
//   clk, rst_n   pixel clock, synchronous active-low reset
//   h_count      horizontal position from the upstream counter
//   trig_v       line-advance pulse, coincident with h_count == 0
//   hsync_n      horizontal sync, active low
//   vsync_n      vertical sync, active low
//   video_on     inside the visible window
//   pixel_x/y    visible column/row, 0 while blanking
//   v_count      current line, 0..V_TOTAL-1
//   frame_end    one-cycle pulse on vertical wrap
// -----------------------------------------------------------------------------
module vga_sync_gen
   import vga_timing_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [9:0] h_count,
   input  logic       trig_v,
   output logic       hsync_n,
   output logic       vsync_n,
   output logic       video_on,
   output logic [9:0] pixel_x,
   output logic [9:0] pixel_y,
   output logic [9:0] v_count,
   output logic       frame_end
);

   // Both counters are 10 bits wide; refuse to elaborate a timing that
   // would not fit.
   if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_timing_too_wide
      $error("vga_sync_gen: H_TOTAL or V_TOTAL exceeds the 10-bit counter range");
   end

   logic [9:0] v_next;
   v_state_t   v_state_next;
   logic       v_wrap;

   vga_v_fsm u_v_fsm (
      .clk        (clk),
      .rst_n      (rst_n),
      .trig_v     (trig_v),
      .v_count    (v_count),
      .v_next     (v_next),
      .state_next (v_state_next),
      .wrap       (v_wrap)
   );

   // Horizontal decode on the sampled h_count, combined with the vertical
   // region the line is moving into at this same edge.
   logic in_hsync;
   logic video_d;

   always_comb begin
      in_hsync = in_range(h_count, HS_START, HS_END);
      video_d  = (h_count < H_VIS_END) && (v_state_next == V_ACTIVE);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         hsync_n   <= 1'b1;
         vsync_n   <= 1'b1;
         video_on  <= 1'b0;
         pixel_x   <= '0;
         pixel_y   <= '0;
         frame_end <= 1'b0;
      end else begin
         hsync_n   <= !in_hsync;
         vsync_n   <= (v_state_next != V_SYNC);
         video_on  <= video_d;
         pixel_x   <= video_d ? h_count : '0;
         pixel_y   <= video_d ? v_next  : '0;
         frame_end <= v_wrap;
      end
   end

endmodule
